display_scheduler: RTL
======================

Name: display_scheduler

Overview:
Shares the 4-digit 7-segment display between two requesters (A and B) and paces the digit scanner. Contains:
- a scan-rate prescaler that generates the scanner's clock-enable pulse;
- a round-robin arbiter with a minimum display hold time;
- the registered 16-bit display word that feeds the scanner's ans input.

It sits between the application datapaths and the scanner.

Parameters:
- SCAN_DIV, 50000: clk cycles per scan_en pulse (>=1).
- HOLD_TICKS, 1024: minimum scan_en pulses a grant is held before it may be released or switched (>=0).

Ports:
- clk  in  1  system clock.
- res  in  1  asynchronous reset, active-low.
- req_a  in  1  requester A wants the display.
- data_a  in  16  requester A display word, 4 BCD/hex nibbles, nibble 0 = rightmost digit.
- req_b  in  1  requester B wants the display.
- data_b  in  16  requester B display word.
- gnt_a  out  1  A owns the display.
- gnt_b  out  1  B owns the display.
- scan_en  out  1  one-cycle pulse every SCAN_DIV clocks; advances the scanner.
- ans  out  16  display word to the scanner.
- digit_mask  out  4  per-digit enable, bit i = digit i lit.

Behaviour:
- Reset (res=0, asynchronous): gnt_a=0, gnt_b=0, scan_en=0, ans=16'h0000, digit_mask=4'b1111, prescaler=0, hold counter=0, state=IDLE, last_served=B (so A wins the first tie).
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - scan_en is registered and high for the one cycle after the count reaches SCAN_DIV-1. The first pulse is at the SCAN_DIV-th rising edge after reset release.
  - SCAN_DIV=1: scan_en is constantly 1 after the first edge.
  - Width is $clog2(SCAN_DIV), minimum 1.
  - Free-running and independent of arbitration.
- Hold counter:
  - Cleared on every grant change.
  - Increments on scan_en while in a GRANT state; saturates at HOLD_TICKS.
  - hold_done = (count == HOLD_TICKS). HOLD_TICKS=0 makes hold_done immediately true.
- States are IDLE, GRANT_A and GRANT_B. gnt_a/gnt_b are registered decodes of the state and are never both 1.
- IDLE:
  - Only req_a: next edge enters GRANT_A.
  - Only req_b: next edge enters GRANT_B.
  - Both: grant the one that is not last_served.
  - Neither: stay.
- GRANT_X (other requester Y):
  - !hold_done: stay, regardless of req_x.
  - hold_done and req_y: go to GRANT_Y on one edge (gnt_x falls and gnt_y rises at the same edge, with no IDLE cycle); last_served=X.
  - hold_done, !req_y, !req_x: go to IDLE; last_served=X.
  - Otherwise: stay.
- ans:
  - On the edge entering GRANT_X and every edge in GRANT_X, ans <= data_x.
  - In IDLE, ans holds its last value.
  - Latency from req to gnt and to ans is 1 cycle.
- A requester dropping req before hold_done does not shorten the hold; its data continues to be sampled.
- Reset asserted mid-grant clears everything immediately. No grant is restored after reset release.

Optional Feature:
- Macro: DISPLAY_SCHEDULER_LZ_BLANK_EN.
- Defined: digit_mask blanks leading zero nibbles of the next ans value, scanning from nibble 3 down. Nibble 0 is always lit. Examples: 16'h0050 -> 4'b0011, 16'h0000 -> 4'b0001, 16'h1000 -> 4'b1111. digit_mask is registered at the same edge as ans.
- Undefined: digit_mask is constant 4'b1111 and no blanking logic is built.

Decomposition:
- Package display_pkg holds:
  - the state enum (IDLE, GRANT_A, GRANT_B);
  - constants DIGITS=4 and NIBBLE_W=4;
  - DISP_W = DIGITS*NIBBLE_W;
  - a requester-id type for last_served.
- One sub-module, scan_prescaler: parameter SCAN_DIV; ports clk, res, scan_en.

Test Plan (SCAN_DIV=4, HOLD_TICKS=2):
- Reset: hold res=0 for 3 cycles -> all outputs at reset values, digit_mask=4'b1111. Release -> scan_en pulses at edges 4, 8, 12 after release, one cycle wide.
- Single requester: req_a=1, data_a=16'h1234 -> next edge gnt_a=1, ans=16'h1234. Change data_a to 16'h5678 -> ans follows one cycle later. gnt_b stays 0 throughout.
- Tie and round-robin: req_a=req_b=1 from IDLE after reset -> gnt_a. After 2 scan_en pulses -> gnt_a=0 and gnt_b=1 on the same edge, ans=data_b. After 2 more pulses with both still requesting -> back to gnt_a.
- Early drop: A granted, req_a dropped after 1 pulse -> gnt_a held until the 2nd pulse, then IDLE on the next edge. ans remains the last data_a (16'h1234).
- Mid-grant reset: res=0 while gnt_b=1 -> gnt_b=0, ans=0 and prescaler=0 asynchronously, with no waiting for clk. After release with req_a=req_b=1 -> gnt_a is granted first.
- LZ blanking (macro defined): grant A with data_a=16'h0050 -> digit_mask=4'b0011. Then 16'h0000 -> 4'b0001. With the macro undefined -> 4'b1111 always.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the display scheduler.
// The leading-zero mask helper exists only when DISPLAY_SCHEDULER_LZ_BLANK_EN
// is defined.
package display_pkg;

   localparam int DIGITS   = 4;
   localparam int NIBBLE_W = 4;
   localparam int DISP_W   = DIGITS * NIBBLE_W;

   // Arbiter states: nobody owns the display, or one requester does.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2
   } state_t;

   // Identity of the requester that was most recently released.
   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_t;

`ifdef DISPLAY_SCHEDULER_LZ_BLANK_EN
   // Light every digit from the most significant non-zero nibble downwards;
   // digit 0 is always lit so a zero word still shows "0".
   function automatic logic [DIGITS-1:0] lz_mask(input logic [DISP_W-1:0] word);
      logic [DIGITS-1:0] mask;
      logic              seen;
      seen = 1'b0;
      mask = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         seen    = seen | (word[i*NIBBLE_W +: NIBBLE_W] != '0);
         mask[i] = seen;
      end
      mask[0] = 1'b1;
      return mask;
   endfunction
`endif

endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: free-running divider producing a one-cycle scan_en pulse
// every SCAN_DIV clocks. With SCAN_DIV=1 the pulse is held high permanently.
module scan_prescaler #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic clk,
   input  logic res,
   output logic scan_en
);

   localparam int               CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             scan_en_q, scan_en_d;

   // Count 0..SCAN_DIV-1 and flag the terminal count for the next cycle.
   always_comb begin
      cnt_d     = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      scan_en_d = (cnt_q == LAST);
   end

   // Counter and pulse registers.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         cnt_q     <= '0;
         scan_en_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         cnt_q     <= cnt_d;
         scan_en_q <= scan_en_d;
      end
   end

   assign scan_en = scan_en_q;

endmodule

// File: rtl/display_scheduler.sv
// display_scheduler: round-robin sharing of the 4-digit display between
// requesters A and B with a minimum hold time counted in scan_en pulses,
// plus the registered display word for the scanner.
// Optional macro DISPLAY_SCHEDULER_LZ_BLANK_EN: blank leading-zero digits.
module display_scheduler
   import display_pkg::*;
#(
   parameter int unsigned SCAN_DIV   = 50000,
   parameter int unsigned HOLD_TICKS = 1024
) (
   input  logic              clk,
   input  logic              res,
   input  logic              req_a,
   input  logic [DISP_W-1:0] data_a,
   input  logic              req_b,
   input  logic [DISP_W-1:0] data_b,
   output logic              gnt_a,
   output logic              gnt_b,
   output logic              scan_en,
   output logic [DISP_W-1:0] ans,
   output logic [DIGITS-1:0] digit_mask
);

   localparam int                HOLD_W   = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

   state_t            state_q, state_d;
   req_id_t           last_q, last_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [DISP_W-1:0] ans_q, ans_d;
   logic              gnt_a_q, gnt_a_d;
   logic              gnt_b_q, gnt_b_d;
   logic              hold_done;
`ifdef DISPLAY_SCHEDULER_LZ_BLANK_EN
   logic [DIGITS-1:0] mask_q, mask_d;
`endif

   scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
      .clk     (clk),
      .res     (res),
      .scan_en (scan_en)
   );

   assign hold_done = (hold_q == HOLD_MAX);

   // Next-state logic: arbitration, hold counting and display word selection.
   always_comb begin
      // NOTE: every _d signal gets a default first so no latch is inferred.
      state_d = state_q;
      last_d  = last_q;
      hold_d  = hold_q;
      ans_d   = ans_q;
`ifdef DISPLAY_SCHEDULER_LZ_BLANK_EN
      mask_d  = mask_q;
`endif

      case (state_q)
         IDLE: begin
            if (req_a && req_b) begin
               state_d = (last_q == REQ_B) ? GRANT_A : GRANT_B;
            end else if (req_a) begin
               state_d = GRANT_A;
            end else if (req_b) begin
               state_d = GRANT_B;
            end
         end
         GRANT_A: begin
            if (hold_done) begin
               if (req_b) begin
                  state_d = GRANT_B;
                  last_d  = REQ_A;
               end else if (!req_a) begin
                  state_d = IDLE;
                  last_d  = REQ_A;
               end
            end
         end
         GRANT_B: begin
            if (hold_done) begin
               if (req_a) begin
                  state_d = GRANT_A;
                  last_d  = REQ_B;
               end else if (!req_b) begin
                  state_d = IDLE;
                  last_d  = REQ_B;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // The hold restarts on any ownership change and counts scan pulses
      // only while someone owns the display.
      if (state_d != state_q) begin
         hold_d = '0;
      end else if ((state_q != IDLE) && scan_en && !hold_done) begin
         hold_d = hold_q + HOLD_W'(1);
      end

      // The owner's word is sampled every cycle it owns the display,
      // including the cycle it is granted; IDLE keeps the last word.
      case (state_d)
         GRANT_A: begin
            ans_d = data_a;
`ifdef DISPLAY_SCHEDULER_LZ_BLANK_EN
            mask_d = lz_mask(data_a);
`endif
         end
         GRANT_B: begin
            ans_d = data_b;
`ifdef DISPLAY_SCHEDULER_LZ_BLANK_EN
            mask_d = lz_mask(data_b);
`endif
         end
         default: ;
      endcase

      gnt_a_d = (state_d == GRANT_A);
      gnt_b_d = (state_d == GRANT_B);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q <= IDLE;
         last_q  <= REQ_B;
         hold_q  <= '0;
         ans_q   <= '0;
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
`ifdef DISPLAY_SCHEDULER_LZ_BLANK_EN
         mask_q  <= '1;
`endif
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         ans_q   <= ans_d;
         gnt_a_q <= gnt_a_d;
         gnt_b_q <= gnt_b_d;
`ifdef DISPLAY_SCHEDULER_LZ_BLANK_EN
         mask_q  <= mask_d;
`endif
      end
   end

   assign gnt_a = gnt_a_q;
   assign gnt_b = gnt_b_q;
   assign ans   = ans_q;
`ifdef DISPLAY_SCHEDULER_LZ_BLANK_EN
   assign digit_mask = mask_q;
`else
   assign digit_mask = {DIGITS{1'b1}};
`endif

endmodule
